// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and types for the grf_sb register file.
// Contents: default widths, the hardwired-zero register index, default-width
// index/data typedefs, and the commit trace format string.
package grf_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  // Register $0 always reads zero and never goes busy.
  localparam int unsigned REG_ZERO = 0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

  // Commit trace line: PC, destination register, written value.
  localparam string TRACE_FMT = "@%h: $%d <= %h";

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register busy bits for the hazard/stall unit.
// A register goes busy when an instruction targeting it issues and is released
// when its value is written back; a same-cycle issue beats the writeback.
// Ports:
//   clk, reset              sole clock; synchronous active-high reset
//   writeEnable, writeReg   writeback (clears busy)
//   issueValid, issueReg    issue of a destination-writing instruction (sets busy)
//   readReg                 packed source indices, one ADDR_WIDTH slice per port
//   srcBusy                 per-port combinational "source has outstanding producer"
//   busyCount               registered number of busy registers
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           writeEnable,
  input  logic [ADDR_WIDTH-1:0]          writeReg,
  input  logic                           issueValid,
  input  logic [ADDR_WIDTH-1:0]          issueReg,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] readReg,
  output logic [READ_PORTS-1:0]          srcBusy,
  output logic [ADDR_WIDTH:0]            busyCount
);

  localparam int unsigned REG_COUNT = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busyNext;
  logic                 doSet;
  logic                 doClear;
  logic                 incC;
  logic                 decC;

  assign doSet   = issueValid  && (issueReg != ADDR_WIDTH'(REG_ZERO));
  assign doClear = writeEnable && (writeReg != ADDR_WIDTH'(REG_ZERO));

  // Clear first, then set, so a new producer supersedes the retiring one.
  always_comb begin
    busyNext = busy;
    if (doClear) busyNext[writeReg] = 1'b0;
    if (doSet)   busyNext[issueReg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Count only real 0->1 and 1->0 transitions so the counter tracks popcount(busy).
  assign incC = doSet && !busy[issueReg];
  assign decC = doClear && busy[writeReg] && !(doSet && (issueReg == writeReg));

  // Busy vector and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      busyCount <= '0;
    end else begin
      busy      <= busyNext;
      busyCount <= busyCount + CNT_WIDTH'(incC) - CNT_WIDTH'(decC);
    end
  end

  // Per-port stall request; with forwarding a same-cycle writeback releases it.
  for (genvar i = 0; i < READ_PORTS; i++) begin : gPort
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fwd;
    assign idx        = readReg[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign fwd        = (BYPASS != 0) && writeEnable && (writeReg == idx);
    assign srcBusy[i] = (idx != ADDR_WIDTH'(REG_ZERO)) && busy[idx] && !fwd;
  end

endmodule

// File: rtl/grf_sb.sv
// grf_sb: parametrised general register file with busy scoreboard for the
// pipelined MIPS core. READ_PORTS combinational read ports, one synchronous
// write port, $0 hardwired to zero, optional same-cycle write-to-read bypass.
// Optional feature: define GRF_TRACE_EN to print a commit trace line for every
// write to a nonzero register (PCReg is otherwise unused).
// Ports:
//   clk, reset                      sole clock; synchronous active-high reset
//   writeEnable/writeReg/writeData  writeback port
//   PCReg                           PC of the committing instruction (trace only)
//   readReg / readData              packed read indices / combinational read data
//   issueValid / issueReg           destination issue into the scoreboard
//   srcBusy                         per-port combinational busy-source flag
//   busyCount                       registered number of busy registers
module grf_sb
  import grf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             writeEnable,
  input  logic [ADDR_WIDTH-1:0]            writeReg,
  input  logic [DATA_WIDTH-1:0]            writeData,
  input  logic [31:0]                      PCReg,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] readReg,
  output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
  input  logic                             issueValid,
  input  logic [ADDR_WIDTH-1:0]            issueReg,
  output logic [READ_PORTS-1:0]            srcBusy,
  output logic [ADDR_WIDTH:0]              busyCount
);

  localparam int unsigned REG_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  doWrite;

  assign doWrite = writeEnable && (writeReg != ADDR_WIDTH'(REG_ZERO));

  // Storage array; writes to $0 are dropped so its entry stays at its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < REG_COUNT; r++) regs[r] <= '0;
    end else if (doWrite) begin
      regs[writeReg] <= writeData;
    end
  end

  // Read muxes: $0 forced to zero, then optional forwarding, then the array.
  for (genvar i = 0; i < READ_PORTS; i++) begin : gRead
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fwd;
    assign idx = readReg[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign fwd = (BYPASS != 0) && writeEnable && (writeReg == idx);
    assign readData[i*DATA_WIDTH +: DATA_WIDTH] =
      (idx == ADDR_WIDTH'(REG_ZERO)) ? '0 :
      fwd                            ? writeData :
                                       regs[idx];
  end

  grf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .READ_PORTS (READ_PORTS),
    .BYPASS     (BYPASS)
  ) uScoreboard (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeReg    (writeReg),
    .issueValid  (issueValid),
    .issueReg    (issueReg),
    .readReg     (readReg),
    .srcBusy     (srcBusy),
    .busyCount   (busyCount)
  );

`ifdef GRF_TRACE_EN
  // Commit trace in the grader format; reset cycles and $0 writes stay silent.
  always_ff @(posedge clk) begin
    if (!reset && doWrite) begin
      $display("%s", $sformatf(TRACE_FMT, PCReg, writeReg, writeData));
    end
  end
`else
  logic unusedPcReg;
  assign unusedPcReg = ^PCReg;
`endif

endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: self-checking bench for grf_sb. Two instances (forwarding on and
// off) share one stimulus stream; a behavioural register-file/busy-set model
// supplies every expected value.
module tb_grf_sb;
  import grf_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned RP   = 2;
  localparam int unsigned NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             writeEnable;
  reg_idx_t         writeReg;
  reg_data_t        writeData;
  logic [31:0]      PCReg;
  logic [RP*AW-1:0] readReg;
  logic             issueValid;
  reg_idx_t         issueReg;

  logic [RP*DW-1:0] readDataA, readDataB;
  logic [RP-1:0]    srcBusyA, srcBusyB;
  logic [AW:0]      busyCountA, busyCountB;

  grf_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(1)) dutA (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeReg(writeReg),
    .writeData(writeData), .PCReg(PCReg), .readReg(readReg), .readData(readDataA),
    .issueValid(issueValid), .issueReg(issueReg), .srcBusy(srcBusyA),
    .busyCount(busyCountA)
  );

  grf_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeReg(writeReg),
    .writeData(writeData), .PCReg(PCReg), .readReg(readReg), .readData(readDataB),
    .issueValid(issueValid), .issueReg(issueReg), .srcBusy(srcBusyB),
    .busyCount(busyCountB)
  );

  // Reference model: architectural register values and the set of busy registers.
  logic [31:0] mRegs [NREG];
  bit          mBusy [NREG];

  int nChecks;
  int nPass;
  bit checksOn;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] expData(input int unsigned idx, input bit byp);
    if (idx == 0) return 32'h0;
    if (byp && writeEnable && (int'(writeReg) == idx)) return writeData;
    return mRegs[idx];
  endfunction

  function automatic bit expBusy(input int unsigned idx, input bit byp);
    if (idx == 0) return 1'b0;
    if (byp && writeEnable && (int'(writeReg) == idx)) return 1'b0;
    return mBusy[idx];
  endfunction

  function automatic int popBusy();
    int n = 0;
    for (int r = 0; r < NREG; r++) if (mBusy[r]) n++;
    return n;
  endfunction

  task automatic compareAll();
    for (int p = 0; p < RP; p++) begin
      int unsigned idx = int'(readReg[p*AW +: AW]);
      checkVal($sformatf("rdA%0d_r%0d", p, idx), 64'(readDataA[p*DW +: DW]), 64'(expData(idx, 1'b1)));
      checkVal($sformatf("rdB%0d_r%0d", p, idx), 64'(readDataB[p*DW +: DW]), 64'(expData(idx, 1'b0)));
      checkVal($sformatf("busyA%0d_r%0d", p, idx), 64'(srcBusyA[p]), 64'(expBusy(idx, 1'b1)));
      checkVal($sformatf("busyB%0d_r%0d", p, idx), 64'(srcBusyB[p]), 64'(expBusy(idx, 1'b0)));
    end
    checkVal("cntA", 64'(busyCountA), 64'(popBusy()));
    checkVal("cntB", 64'(busyCountB), 64'(popBusy()));
  endtask

  // Apply one cycle of inputs at the falling edge and check the pre-edge outputs.
  task automatic drive(input bit rst, input bit we, input int unsigned wr,
                       input logic [31:0] wd, input logic [31:0] pc, input bit iv,
                       input int unsigned ir, input int unsigned r0, input int unsigned r1);
    @(negedge clk);
    reset       = rst;
    writeEnable = we;
    writeReg    = AW'(wr);
    writeData   = wd;
    PCReg       = pc;
    issueValid  = iv;
    issueReg    = AW'(ir);
    readReg     = {AW'(r1), AW'(r0)};
    #1;
    if (checksOn) compareAll();
  endtask

  // Advance the model across the rising edge using the stable inputs.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        mRegs[r] = 32'h0;
        mBusy[r] = 1'b0;
      end
    end else begin
      if (writeEnable && writeReg != 0) begin
        mRegs[writeReg] = writeData;
        mBusy[writeReg] = 1'b0;
      end
      if (issueValid && issueReg != 0) mBusy[issueReg] = 1'b1;
    end
  endtask

  function automatic int unsigned rndIdx();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, NREG - 1);
    return $urandom_range(0, 7);
  endfunction

  initial begin
    nChecks  = 0;
    nPass    = 0;
    checksOn = 1'b0;

    // Reset then read all.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    checksOn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 10, 0);
    checkVal("t1_rd10", 64'(readDataA[31:0]), 64'h0);
    checkVal("t1_srcBusy", 64'(srcBusyA), 64'h0);
    checkVal("t1_cnt", 64'(busyCountA), 64'h0);
    tick();

    // $0 protection and a normal write.
    drive(0, 1, 0, 32'h3, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("t2_r0", 64'(readDataA[31:0]), 64'h0);
    tick();
    drive(0, 1, 10, 32'h10, 32'h12345678, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 10, 0);
    checkVal("t2_r10A", 64'(readDataA[31:0]), 64'h10);
    checkVal("t2_r10B", 64'(readDataB[31:0]), 64'h10);
    tick();

    // Same-cycle forwarding versus array-only read.
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5);
    checkVal("t3_bypA", 64'(readDataA[63:32]), 64'hDEADBEEF);
    checkVal("t3_nobypB", 64'(readDataB[63:32]), 64'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5);
    checkVal("t3_afterB", 64'(readDataB[63:32]), 64'hDEADBEEF);
    tick();

    // Scoreboard life cycle of reg 7.
    drive(0, 0, 0, 0, 0, 1, 7, 7, 0);
    checkVal("t4_issueSame", 64'(srcBusyA[0]), 64'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkVal("t4_busy", 64'(srcBusyA[0]), 64'h1);
    checkVal("t4_cnt1", 64'(busyCountA), 64'h1);
    tick();
    drive(0, 1, 7, 32'h77, 0, 0, 0, 7, 0);
    checkVal("t4_wbA", 64'(srcBusyA[0]), 64'h0);
    checkVal("t4_wbB", 64'(srcBusyB[0]), 64'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkVal("t4_cnt0", 64'(busyCountA), 64'h0);
    tick();

    // Simultaneous set and clear on reg 3, then issue to $0.
    drive(0, 0, 0, 0, 0, 1, 3, 0, 0); tick();
    drive(0, 1, 3, 32'h33, 0, 1, 3, 3, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkVal("t5_busy3", 64'(srcBusyA[0]), 64'h1);
    checkVal("t5_cnt", 64'(busyCountA), 64'h1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("t5_cntZero", 64'(busyCountA), 64'h1);
    tick();

    // Reset in the middle of activity overrides a same-cycle write.
    drive(0, 1, 2, 32'h55, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 2, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 4, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2, 0);
    checkVal("t6_cnt4", 64'(busyCountA), 64'h4);
    checkVal("t6_r2", 64'(readDataB[31:0]), 64'h55);
    tick();
    drive(1, 1, 2, 32'h99, 0, 1, 5, 2, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2, 3);
    checkVal("t6_r2rst", 64'(readDataA[31:0]), 64'h0);
    checkVal("t6_cntRst", 64'(busyCountA), 64'h0);
    checkVal("t6_srcRst", 64'(srcBusyA), 64'h0);
    tick();

    // Randomised traffic; disabled ports carry garbage indices/data.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1), rndIdx(), $urandom(),
            $urandom(), $urandom_range(0, 1), rndIdx(), rndIdx(), rndIdx());
      tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
